// File: rtl/seq_array_multiplier.sv
// Iterative unsigned array multiplier.
// Each RUN cycle folds ROW_BITS shifted partial-product rows into a 2*WIDTH
// accumulator, so one product takes WIDTH/ROW_BITS cycles. In approximate
// mode the low APPROX_COLS absolute product columns of every row are
// discarded before accumulation. WIDTH must be a multiple of ROW_BITS.
// Operands and product each move through a valid/ready handshake.

module seq_array_multiplier #(
   parameter int WIDTH       = 8,
   parameter int ROW_BITS    = 2,
   parameter int APPROX_COLS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               approx,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int PW     = 2 * WIDTH;
   localparam int N      = WIDTH / ROW_BITS;
   localparam int STEP_W = (N + 1 > 2) ? $clog2(N + 1) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

   // Column c survives approximation only when it lies at or above the cutoff.
   function automatic logic [PW-1:0] buildMask();
      logic [PW-1:0] m;
      m = '0;
      for (int c = 0; c < PW; c++) begin
         m[c] = (c >= APPROX_COLS);
      end
      return m;
   endfunction

   localparam logic [PW-1:0] APPROX_MASK = buildMask();

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  aShift_q;
   logic [PW-1:0]     bShift_q;
   logic [PW-1:0]     acc_q;
   logic [STEP_W-1:0] step_q;
   logic              approx_q;
   logic              inReady_q;
   logic              outValid_q;
   logic              busy_q;
   logic [PW-1:0]     product_q;

   logic [PW-1:0]     rowSum_d;
   logic [PW-1:0]     acc_d;
   logic [PW-1:0]     row;

   // The multiplier is consumed from its low end and the multiplicand is
   // pre-shifted by the rows already processed, so row j of this step sits at
   // bShift_q << j, which is its absolute column position.
   always_comb begin
      rowSum_d = '0;
      row      = '0;
      for (int j = 0; j < ROW_BITS; j++) begin
         row = aShift_q[j] ? (bShift_q << j) : '0;
         if (approx_q) begin
            row = row & APPROX_MASK;
         end
         rowSum_d = rowSum_d + row;
      end
      acc_d = acc_q + rowSum_d;
   end

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         aShift_q   <= '0;
         bShift_q   <= '0;
         acc_q      <= '0;
         step_q     <= '0;
         approx_q   <= 1'b0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
         product_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  aShift_q  <= a;
                  bShift_q  <= {{WIDTH{1'b0}}, b};
                  approx_q  <= approx;
                  acc_q     <= '0;
                  step_q    <= '0;
                  inReady_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               aShift_q <= aShift_q >> ROW_BITS;
               bShift_q <= bShift_q << ROW_BITS;
               step_q   <= step_q + 1'b1;
               if (step_q == LAST_STEP) begin
                  product_q  <= acc_d;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               inReady_q  <= 1'b1;
               outValid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign busy      = busy_q;
   assign product   = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Testbench for seq_array_multiplier (WIDTH=8, ROW_BITS=2, APPROX_COLS=4).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_seq_array_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        approx;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   int checks = 0;
   int passes = 0;

   typedef struct {
      string       name;
      logic [7:0]  a;
      logic [7:0]  b;
      logic        approx;
      logic [15:0] expProd;
   } vec_t;

   vec_t vecs[10];

   seq_array_multiplier #(
      .WIDTH      (8),
      .ROW_BITS   (2),
      .APPROX_COLS(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .approx   (approx),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product  (product),
      .busy     (busy)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents one operand pair, waits for the product and reports latency in edges.
   task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vap,
                                output logic [15:0] prod, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      approx   = vap;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~va;
      b        = ~vb;
      approx   = ~vap;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      prod = product;
   endtask

   // Completes the output handshake.
   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] prod;
      int          lat;

      vecs[0] = '{"ff_ff_exact",  8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[1] = '{"13_11_exact",  8'd13, 8'd11, 1'b0, 16'h008F};
      vecs[2] = '{"ff_ff_approx", 8'hFF, 8'hFF, 1'b1, 16'hFDD0};
      vecs[3] = '{"10_01_approx", 8'h10, 8'h01, 1'b1, 16'h0010};
      vecs[4] = '{"01_0f_approx", 8'h01, 8'h0F, 1'b1, 16'h0000};
      vecs[5] = '{"a5_3c_exact",  8'hA5, 8'h3C, 1'b0, 16'h26AC};
      vecs[6] = '{"a5_3c_approx", 8'hA5, 8'h3C, 1'b1, 16'h26A0};
      vecs[7] = '{"80_ff_approx", 8'h80, 8'hFF, 1'b1, 16'h7F80};
      vecs[8] = '{"00_5a_exact",  8'h00, 8'h5A, 1'b0, 16'h0000};
      vecs[9] = '{"3_5_exact",    8'd3,  8'd5,  1'b0, 16'h000F};

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      approx    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy",      32'(busy),      32'd0);
      checkOutput("reset_product",   32'(product),   32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

      // Table-driven products with latency and handshake state checks.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].approx, prod, lat);
         checkOutput({vecs[i].name, "_product"}, 32'(prod), 32'(vecs[i].expProd));
         checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'd4);
         checkOutput({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
         checkOutput({vecs[i].name, "_in_ready_done"}, 32'(in_ready), 32'd0);
         drain();
         checkOutput({vecs[i].name, "_idle_valid"}, 32'(out_valid), 32'd0);
         checkOutput({vecs[i].name, "_idle_ready"}, 32'(in_ready), 32'd1);
      end

      // Backpressure: product holds while the producer side thrashes.
      applyStimulus(8'h21, 8'h07, 1'b0, prod, lat);
      checkOutput("bp_product", 32'(prod), 32'h00E7);
      for (int c = 0; c < 5; c++) begin
         in_valid = ~in_valid;
         a        = 8'($urandom_range(0, 255));
         b        = 8'($urandom_range(0, 255));
         @(negedge clk);
         checkOutput("bp_hold_product",  32'(product),   32'h00E7);
         checkOutput("bp_hold_in_ready", 32'(in_ready),  32'd0);
         checkOutput("bp_hold_valid",    32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      drain();
      checkOutput("bp_release_in_ready", 32'(in_ready),  32'd1);
      checkOutput("bp_release_valid",    32'(out_valid), 32'd0);
      checkOutput("bp_release_busy",     32'(busy),      32'd0);
      checkOutput("bp_product_kept",     32'(product),   32'h00E7);

      // Reset two cycles into RUN discards the operation.
      @(negedge clk);
      in_valid = 1'b1;
      a        = 8'hAA;
      b        = 8'h55;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_product",   32'(product),   32'd0);
      checkOutput("midrst_busy",      32'(busy),      32'd0);
      checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'd3, 8'd5, 1'b0, prod, lat);
      checkOutput("after_rst_product", 32'(prod), 32'd15);
      checkOutput("after_rst_latency", 32'(lat),  32'd4);
      drain();

      // Back-to-back with out_ready held high.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 8'h00;
      b         = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      a = 8'h01;
      b = 8'h80;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("b2b_first_latency", 32'(lat),     32'd4);
      checkOutput("b2b_first_product", 32'(product), 32'h0000);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_handshake_in_ready", 32'(in_ready),  32'd1);
      checkOutput("b2b_handshake_valid",    32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("b2b_second_accepted", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("b2b_second_latency", 32'(lat),     32'd4);
      checkOutput("b2b_second_product", 32'(product), 32'h0080);
      @(negedge clk);
      checkOutput("b2b_drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
